// File: rtl/sub_serial_if.sv
// Request/result bundle for the bit-serial subtractor: operands and start in,
// busy/done/result out.
interface sub_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   d;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input d);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output d);
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: computes a - b LSB-first through one borrow flop and
// presents {borrow, difference} for one done cycle after WIDTH run cycles.
module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  sub_serial_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             diff;
  logic             br_next;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    diff    = ra[0] ^ rb[0] ^ br;
    br_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      ra       <= '0;
      rb       <= '0;
      rd       <= '0;
      br       <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra       <= bus.a;
            rb       <= bus.b;
            rd       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= {diff, rd[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + 1'b1;
          // Last bit: publish the completed word, including the bit computed now.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bus.d    <= {br_next, diff, rd[WIDTH-1:1]};
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
